// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular in-order retirement buffer for an SS-wide superscalar core.
//   Groups of SS instructions are dispatched all-or-none into consecutive
//   slots at the tail. Completion broadcasts on the CDB mark slots done.
//   Up to SS done entries retire per cycle, strictly in order from the head.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   flush                 discard every entry (misprediction recovery)
//   dispatch_valid        an SS-wide group is offered
//   dispatch_rd_arch/phys per-lane architectural / physical destination
//   dispatch_ready        room for a whole group (registered occupancy only)
//   dispatch_rob_id       slot each lane would be assigned this cycle
//   cdb_valid/cdb_rob_id  per-lane completion broadcasts
//   commit_valid          lane retires this cycle (in-order prefix)
//   commit_rd_arch/phys   fields of the retiring entries
//   commit_rob_id         slot of the retiring entries
//   occupancy             number of valid entries
module reorder_buffer #(
  parameter int SS        = 2,
  parameter int ROB_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       dispatch_valid,
  input  logic [4:0] dispatch_rd_arch [SS],
  input  logic [5:0] dispatch_rd_phys [SS],
  output logic       dispatch_ready,
  output logic [7:0] dispatch_rob_id  [SS],
  input  logic       cdb_valid        [SS],
  input  logic [7:0] cdb_rob_id       [SS],
  output logic       commit_valid     [SS],
  output logic [4:0] commit_rd_arch   [SS],
  output logic [5:0] commit_rd_phys   [SS],
  output logic [7:0] commit_rob_id    [SS],
  output logic [$clog2(ROB_DEPTH):0] occupancy
);

  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int OCC_W = IDX_W + 1;

  // Pointers carry one extra wrap bit: equal low bits with equal wrap bits
  // means empty, differing wrap bits means full.
  logic [IDX_W:0]         head;
  logic [IDX_W:0]         tail;
  logic [OCC_W-1:0]       occ;
  logic [ROB_DEPTH-1:0]   valid;
  logic [ROB_DEPTH-1:0]   done;
  logic [4:0]             arch_mem [ROB_DEPTH];
  logic [5:0]             phys_mem [ROB_DEPTH];

  logic [IDX_W-1:0]       disp_slot   [SS];
  logic [IDX_W-1:0]       commit_slot [SS];
  logic [IDX_W-1:0]       cdb_slot    [SS];
  logic [OCC_W-1:0]       n_commit;
  logic                   accept;
  logic                   chain;
  logic                   unused_cdb_hi;

  assign occupancy = occ;

  always_comb begin
    dispatch_ready = (occ <= OCC_W'(ROB_DEPTH - SS));
    accept         = dispatch_valid && dispatch_ready && !flush;
    unused_cdb_hi  = 1'b0;
    for (int k = 0; k < SS; k++) begin
      disp_slot[k]       = tail[IDX_W-1:0] + IDX_W'(k);
      dispatch_rob_id[k] = 8'(disp_slot[k]);
      cdb_slot[k]        = cdb_rob_id[k][IDX_W-1:0];
      unused_cdb_hi      = unused_cdb_hi ^ (^cdb_rob_id[k][7:IDX_W]);
    end
  end

  // Retirement is an in-order prefix: lane k retires only if every older lane
  // retires too. Flush (and reset) suppress retirement for the cycle.
  always_comb begin
    chain    = !rst && !flush;
    n_commit = '0;
    for (int k = 0; k < SS; k++) begin
      commit_slot[k]    = head[IDX_W-1:0] + IDX_W'(k);
      chain             = chain && valid[commit_slot[k]] && done[commit_slot[k]];
      commit_valid[k]   = chain;
      commit_rd_arch[k] = arch_mem[commit_slot[k]];
      commit_rd_phys[k] = phys_mem[commit_slot[k]];
      commit_rob_id[k]  = 8'(commit_slot[k]);
      if (chain) n_commit = n_commit + OCC_W'(1);
    end
  end

  // Control state. Order within the edge: CDB marks, then commit clears,
  // then dispatch writes. Dispatch slots are always free and commit slots
  // always occupied, so the last two never touch the same slot.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
      done  <= '0;
      head  <= '0;
      tail  <= '0;
      occ   <= '0;
    end else begin
      for (int i = 0; i < SS; i++) begin
        if (cdb_valid[i] && valid[cdb_slot[i]]) done[cdb_slot[i]] <= 1'b1;
      end
      for (int k = 0; k < SS; k++) begin
        if (commit_valid[k]) begin
          valid[commit_slot[k]] <= 1'b0;
          done[commit_slot[k]]  <= 1'b0;
        end
      end
      if (accept) begin
        for (int k = 0; k < SS; k++) begin
          valid[disp_slot[k]] <= 1'b1;
          done[disp_slot[k]]  <= 1'b0;
        end
      end
      head <= head + n_commit;
      tail <= tail + (accept ? OCC_W'(SS) : OCC_W'(0));
      occ  <= occ + (accept ? OCC_W'(SS) : OCC_W'(0)) - n_commit;
    end
  end

  // Payload storage carries no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < SS; k++) begin
        arch_mem[disp_slot[k]] <= dispatch_rd_arch[k];
        phys_mem[disp_slot[k]] <= dispatch_rd_phys[k];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
//   Scoreboard bench for reorder_buffer (SS=2, ROB_DEPTH=8). Accepted groups
//   are queued with their expected IDs and payload; every retiring lane pops
//   and compares. Directed checks cover occupancy, ready and commit timing.
module tb_reorder_buffer;

  localparam int SS = 2;
  localparam int D  = 8;

  logic       clk = 1'b0;
  logic       rst, flush, dispatch_valid, dispatch_ready;
  logic [4:0] dispatch_rd_arch [SS];
  logic [5:0] dispatch_rd_phys [SS];
  logic [7:0] dispatch_rob_id  [SS];
  logic       cdb_valid        [SS];
  logic [7:0] cdb_rob_id       [SS];
  logic       commit_valid     [SS];
  logic [4:0] commit_rd_arch   [SS];
  logic [5:0] commit_rd_phys   [SS];
  logic [7:0] commit_rob_id    [SS];
  logic [3:0] occupancy;

  always #5 clk = ~clk;

  reorder_buffer #(.SS(SS), .ROB_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid),
    .dispatch_rd_arch(dispatch_rd_arch), .dispatch_rd_phys(dispatch_rd_phys),
    .dispatch_ready(dispatch_ready), .dispatch_rob_id(dispatch_rob_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .commit_valid(commit_valid), .commit_rd_arch(commit_rd_arch),
    .commit_rd_phys(commit_rd_phys), .commit_rob_id(commit_rob_id),
    .occupancy(occupancy)
  );

  typedef struct { int id; int arch; int phys; } ent_t;
  ent_t sbq[$];
  int   n_cmp  = 0;
  int   n_mis  = 0;
  int   m_tail = 0;
  int   seq    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; dispatch_valid = 1'b0;
    for (int k = 0; k < SS; k++) begin
      cdb_valid[k] = 1'b0; cdb_rob_id[k] = '0;
      dispatch_rd_arch[k] = '0; dispatch_rd_phys[k] = '0;
    end
  endtask

  task automatic set_disp();
    dispatch_valid = 1'b1;
    for (int k = 0; k < SS; k++) begin
      dispatch_rd_arch[k] = 5'((seq + k + 1) % 32);
      dispatch_rd_phys[k] = 6'((seq * 5 + k + 9) % 64);
    end
  endtask

  task automatic cdb(input int lane, input int id);
    cdb_valid[lane]  = 1'b1;
    cdb_rob_id[lane] = 8'(id);
  endtask

  // One clock: sample retiring lanes against the scoreboard, check the
  // dispatch offer, record an expected acceptance, then take the edge.
  task automatic cycle(input bit exp_acc);
    ent_t e;
    #1;
    if (rst || flush) begin
      check("flush_cv", 32'({commit_valid[0], commit_valid[1]}), 32'd0);
    end else begin
      for (int k = 0; k < SS; k++) begin
        if (commit_valid[k]) begin
          if (sbq.size() == 0) check("sb_underflow", 32'd1, 32'd0);
          else begin
            e = sbq.pop_front();
            check("cmt_id",   32'(commit_rob_id[k]),  32'(e.id));
            check("cmt_arch", 32'(commit_rd_arch[k]), 32'(e.arch));
            check("cmt_phys", 32'(commit_rd_phys[k]), 32'(e.phys));
          end
        end
      end
    end
    if (dispatch_valid && !flush && !rst) begin
      check("rdy", 32'(dispatch_ready), 32'(exp_acc));
      for (int k = 0; k < SS; k++)
        check("did", 32'(dispatch_rob_id[k]), 32'((m_tail + k) % D));
    end
    if (rst || flush) begin
      sbq.delete();
      m_tail = 0;
    end else if (dispatch_valid && exp_acc) begin
      for (int k = 0; k < SS; k++) begin
        e.id = (m_tail + k) % D;
        e.arch = int'(dispatch_rd_arch[k]);
        e.phys = int'(dispatch_rd_phys[k]);
        sbq.push_back(e);
      end
      m_tail = (m_tail + SS) % D;
      seq += SS;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a;
    idle();
    rst = 1'b1;
    cycle(0); cycle(0);
    idle();
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_rdy", 32'(dispatch_ready), 32'd1);
    check("rst_did0", 32'(dispatch_rob_id[0]), 32'd0);
    check("rst_did1", 32'(dispatch_rob_id[1]), 32'd1);
    check("rst_cv", 32'({commit_valid[0], commit_valid[1]}), 32'd0);

    // Fill to full, offer a fifth group, then drain.
    for (int g = 0; g < 4; g++) begin
      idle(); set_disp(); cycle(1);
      check("fill_occ", 32'(occupancy), 32'(2 * (g + 1)));
      check("fill_rdy", 32'(dispatch_ready), 32'((2 * (g + 1)) <= 6));
    end
    idle(); set_disp(); cycle(0);
    check("full_occ", 32'(occupancy), 32'd8);
    check("full_did0", 32'(dispatch_rob_id[0]), 32'd0);
    for (int g = 0; g < 4; g++) begin
      idle(); cdb(0, 2 * g); cdb(1, 2 * g + 1); cycle(0);
    end
    idle(); cycle(0); cycle(0);
    check("drain_occ", 32'(occupancy), 32'd0);

    // IDs 0..3; complete 1 then 0.
    idle(); set_disp(); cycle(1);
    idle(); set_disp(); cycle(1);
    idle(); cdb(0, 1); cycle(0);
    idle();
    check("hold1_cv0", 32'(commit_valid[0]), 32'd0);
    check("hold1_occ", 32'(occupancy), 32'd4);
    cdb(0, 0); cycle(0);
    idle();
    check("pair_cv0", 32'(commit_valid[0]), 32'd1);
    check("pair_cv1", 32'(commit_valid[1]), 32'd1);
    check("pair_id0", 32'(commit_rob_id[0]), 32'd0);
    check("pair_id1", 32'(commit_rob_id[1]), 32'd1);
    cycle(0);
    check("pair_occ", 32'(occupancy), 32'd2);

    // Out of order: 3 before 2.
    idle(); cdb(1, 3); cycle(0);
    idle();
    check("hold3_cv0", 32'(commit_valid[0]), 32'd0);
    cdb(0, 2); cycle(0);
    idle();
    check("ooo_cv0", 32'(commit_valid[0]), 32'd1);
    check("ooo_cv1", 32'(commit_valid[1]), 32'd1);
    check("ooo_id0", 32'(commit_rob_id[0]), 32'd2);
    check("ooo_id1", 32'(commit_rob_id[1]), 32'd3);
    cycle(0);
    check("ooo_occ", 32'(occupancy), 32'd0);

    // Simultaneous dispatch at occupancy 6 with commit of 2.
    for (int g = 0; g < 3; g++) begin
      idle(); set_disp(); cycle(1);
    end
    check("six_occ", 32'(occupancy), 32'd6);
    idle(); cdb(0, 4); cdb(1, 5); cycle(0);
    idle(); set_disp(); cycle(1);
    idle();
    check("same_edge_occ", 32'(occupancy), 32'd6);
    cdb(0, 4); cycle(0);
    idle();
    check("inv_cdb_occ", 32'(occupancy), 32'd6);
    check("inv_cdb_cv0", 32'(commit_valid[0]), 32'd0);
    cdb(0, 6); cdb(1, 6); cycle(0);
    idle();
    check("dup_cv0", 32'(commit_valid[0]), 32'd1);
    check("dup_cv1", 32'(commit_valid[1]), 32'd0);
    cdb(0, 7); cdb(1, 0); cycle(0);
    idle(); cdb(0, 1); cdb(1, 2); cycle(0);
    idle(); cdb(0, 3); cycle(0);
    idle(); cycle(0); cycle(0); cycle(0);
    check("mix_occ", 32'(occupancy), 32'd0);

    // Wrap rounds.
    for (int r = 0; r < 6; r++) begin
      a = m_tail;
      idle(); set_disp(); cycle(1);
      idle(); cdb(0, a); cdb(1, (a + 1) % D); cycle(0);
      idle(); cycle(0);
      check("wrap_occ", 32'(occupancy), 32'd0);
      check("wrap_rdy", 32'(dispatch_ready), 32'd1);
    end

    // Flush with occupancy 5, CDB and dispatch pending.
    a = m_tail;
    for (int g = 0; g < 3; g++) begin
      idle(); set_disp(); cycle(1);
    end
    idle(); cdb(0, a); cycle(0);
    idle(); cycle(0);
    check("pre_flush_occ", 32'(occupancy), 32'd5);
    cdb(0, (a + 1) % D); cycle(0);
    idle();
    check("pre_flush_cv0", 32'(commit_valid[0]), 32'd1);
    flush = 1'b1; set_disp(); cdb(1, (a + 2) % D); cycle(0);
    idle();
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_did0", 32'(dispatch_rob_id[0]), 32'd0);
    check("flush_did1", 32'(dispatch_rob_id[1]), 32'd1);
    check("flush_cv0", 32'(commit_valid[0]), 32'd0);
    check("flush_rdy", 32'(dispatch_ready), 32'd1);

    // rst together with flush mid-operation, then normal operation.
    set_disp(); cycle(1);
    idle(); cdb(0, 0); cycle(0);
    idle(); rst = 1'b1; flush = 1'b1; set_disp(); cycle(0);
    idle();
    check("rstfl_occ", 32'(occupancy), 32'd0);
    check("rstfl_cv0", 32'(commit_valid[0]), 32'd0);
    check("rstfl_did0", 32'(dispatch_rob_id[0]), 32'd0);
    set_disp(); cycle(1);
    idle(); cdb(0, 0); cdb(1, 1); cycle(0);
    idle();
    check("post_cv1", 32'(commit_valid[1]), 32'd1);
    cycle(0);
    check("post_occ", 32'(occupancy), 32'd0);
    check("sb_left", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
